// File: rtl/shift_reg_ctrl_if.sv
// Handshake and shift-register control bundle for shift_reg_ctrl.
// master: word producer / clear requester side; slave: the controller.
interface shift_reg_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             clear_req;
    logic             sr_serial;
    logic             sr_shift_en;
    logic             sr_clear;
    logic             sr_latch;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, clear_req,
        input  in_ready, sr_serial, sr_shift_en, sr_clear, sr_latch, busy, done
    );

    modport slave (
        input  in_valid, in_data, clear_req,
        output in_ready, sr_serial, sr_shift_en, sr_clear, sr_latch, busy, done
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Serialises handshaked words into an external SIPO shift register, strobes its latch,
// and sequences clears. Define SHIFT_REG_CTRL_LSB_FIRST_EN to send words LSB-first.
module shift_reg_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit          HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state,     state_nxt;
    logic [WIDTH-1:0] hold,      hold_nxt;
    logic [CNT_W-1:0] bit_cnt,   bit_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt,   gap_cnt_nxt;
    logic [WIDTH-1:0] hold_shifted;
    logic             tx_bit_nxt;
    logic             serial_nxt;
    logic             shift_en_nxt;
    logic             clear_nxt;
    logic             latch_nxt;
    logic             busy_nxt;

    // Only the accept path may look at clear_req combinationally
    assign bus.in_ready = (state == ST_IDLE) && !bus.clear_req;

    // Next state, datapath and output decode (outputs registered from next state)
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;

`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
        hold_shifted = hold >> 1;
`else
        hold_shifted = hold << 1;
`endif

        case (state)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_nxt = ST_CLEAR;
                end else if (bus.in_valid) begin
                    state_nxt   = ST_SHIFT;
                    hold_nxt    = bus.in_data;
                    bit_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                hold_nxt = hold_shifted;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = ST_LATCH;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (HAS_GAP) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
        tx_bit_nxt = hold_nxt[0];
`else
        tx_bit_nxt = hold_nxt[WIDTH-1];
`endif

        shift_en_nxt = (state_nxt == ST_SHIFT);
        serial_nxt   = shift_en_nxt && tx_bit_nxt;
        clear_nxt    = (state_nxt == ST_CLEAR);
        latch_nxt    = (state_nxt == ST_LATCH);
        busy_nxt     = (state_nxt != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            hold            <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            bus.sr_serial   <= 1'b0;
            bus.sr_shift_en <= 1'b0;
            bus.sr_clear    <= 1'b0;
            bus.sr_latch    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state           <= state_nxt;
            hold            <= hold_nxt;
            bit_cnt         <= bit_cnt_nxt;
            gap_cnt         <= gap_cnt_nxt;
            bus.sr_serial   <= serial_nxt;
            bus.sr_shift_en <= shift_en_nxt;
            bus.sr_clear    <= clear_nxt;
            bus.sr_latch    <= latch_nxt;
            bus.busy        <= busy_nxt;
            bus.done        <= latch_nxt;
        end
    end
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: timeline reference model plus a model of the
// external shift register, directed scenarios followed by randomized traffic.
module tb_shift_reg_ctrl;
    localparam int unsigned W   = 4;
    localparam int unsigned GAP = 1;

    logic clk;
    logic reset;

    shift_reg_ctrl_if #(.WIDTH(W)) bus ();

    shift_reg_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference timeline: cycle c is the interval following clock edge c
    int         cyc       = 0;
    int         idle_from = 0;
    int         kind      = 0;   // 0 none, 1 word, 2 clear
    int         ev_start  = 0;
    int         accepted  = 0;
    logic [W-1:0] ev_word = '0;
    logic [W-1:0] sreg    = '0;
    logic [W-1:0] exp_q[$];
    int           latch_cycles[$];
    logic s_shift = 1'b0, s_serial = 1'b0, s_clear = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
        return w[i];
`else
        return w[W-1-i];
`endif
    endfunction

    // Word the external register should hold once all bits are in
    function automatic logic [W-1:0] ref_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = exp_bit(w, i);
        return r;
    endfunction

    task automatic check_outputs();
        logic e_shift, e_ser, e_clr, e_lat, e_busy;
        logic [W-1:0] w;
        e_shift = (kind == 1) && (cyc >= ev_start) && (cyc < ev_start + W);
        e_ser   = e_shift ? exp_bit(ev_word, cyc - ev_start) : 1'b0;
        e_lat   = (kind == 1) && (cyc == ev_start + W);
        e_clr   = (kind == 2) && (cyc == ev_start);
        e_busy  = (cyc < idle_from);
        check_eq("sr_shift_en", bus.sr_shift_en, e_shift);
        check_eq("sr_serial",   bus.sr_serial,   e_ser);
        check_eq("sr_clear",    bus.sr_clear,    e_clr);
        check_eq("sr_latch",    bus.sr_latch,    e_lat);
        check_eq("done",        bus.done,        e_lat);
        check_eq("busy",        bus.busy,        e_busy);
        check_eq("exclusive", 32'(int'(bus.sr_shift_en) + int'(bus.sr_clear) + int'(bus.sr_latch) <= 1), 1);
        if (bus.sr_latch === 1'b1) begin
            latch_cycles.push_back(cyc);
            check_eq("latch_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_eq("latch_word", sreg, ref_word(w));
            end
        end
        s_shift  = bus.sr_shift_en;
        s_serial = bus.sr_serial;
        s_clear  = bus.sr_clear;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic cr);
        if (cyc >= idle_from) begin
            if (cr) begin
                kind      = 2;
                ev_start  = cyc + 1;
                idle_from = cyc + 2;
            end else if (v) begin
                kind      = 1;
                ev_start  = cyc + 1;
                ev_word   = d;
                idle_from = cyc + 2 + W + GAP;
                exp_q.push_back(d);
                accepted++;
            end
        end
        cyc++;
    endtask

    // One clock: drive inputs, check in_ready, take the edge, check registered outputs
    task automatic step(input logic v, input logic [W-1:0] d, input logic cr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.clear_req = cr;
        #1;
        check_eq("in_ready", bus.in_ready, 32'((reset || cyc >= idle_from) && !cr));
        @(posedge clk);
        if (s_clear) sreg = '0;
        else if (s_shift) sreg = {sreg[W-2:0], s_serial};
        if (!reset) model_edge(v, d, cr);
        else cyc++;
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic reset_pulse(input int hold_cycles);
        #2;
        reset = 1'b1;
        if (kind == 1 && cyc < ev_start + W && exp_q.size() > 0) void'(exp_q.pop_back());
        kind      = 0;
        idle_from = cyc;
        #1;
        check_outputs();
        check_eq("rst_in_ready", bus.in_ready, 32'(!bus.clear_req));
        for (int i = 0; i < hold_cycles; i++) step(1'b0, '0, 1'b0);
        #3;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < W + GAP + 4; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        int acc0, lc0;
        logic cr, v;
        logic [W-1:0] d;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.clear_req = 1'b0;
        #3;
        check_outputs();
        check_eq("reset_in_ready", bus.in_ready, 1);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        // Single word 1011
        step(1'b1, W'(32'hB), 1'b0);
        drain();
        check_eq("single_accepted", 32'(accepted), 1);

        // Back-to-back words A then 5 with in_valid held high
        acc0 = accepted;
        lc0  = latch_cycles.size();
        for (int i = 0; i < 40 && accepted < acc0 + 2; i++)
            step(1'b1, (accepted == acc0) ? W'(32'hA) : W'(32'h5), 1'b0);
        drain();
        check_eq("b2b_latch_count", 32'(latch_cycles.size() - lc0), 2);
        if (latch_cycles.size() >= lc0 + 2)
            check_eq("b2b_spacing", 32'(latch_cycles[lc0+1] - latch_cycles[lc0]), W + 2 + GAP);

        // Clear has priority over a pending word
        step(1'b1, W'(32'h9), 1'b1);
        step(1'b1, W'(32'h9), 1'b0);
        check_eq("clear_sreg_zero", sreg, 0);
        acc0 = accepted;
        step(1'b1, W'(32'h9), 1'b0);
        check_eq("post_clear_accept", 32'(accepted - acc0), 1);
        drain();

        // Reset after two shift cycles, then a clean word
        step(1'b1, W'(32'h6), 1'b0);
        step(1'b0, '0, 1'b0);
        lc0 = latch_cycles.size();
        reset_pulse(2);
        drain();
        check_eq("abort_no_latch", 32'(latch_cycles.size() - lc0), 0);
        step(1'b1, W'(32'hC), 1'b0);
        drain();
        check_eq("after_abort_latch", 32'(latch_cycles.size() - lc0), 1);

        // Randomized traffic with held clear requests and an occasional reset
        cr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (cr && s_clear) cr = 1'b0;
            else if (!cr && ($urandom % 16 == 0)) cr = 1'b1;
            v = ($urandom % 3) != 0;
            d = W'($urandom);
            step(v, d, cr);
            if (i % 150 == 149) begin
                cr = 1'b0;
                bus.clear_req = 1'b0;
                reset_pulse(1 + ($urandom % 3));
            end
        end
        drain();
        check_eq("pending_words", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencer that drives a serial-in/parallel-out shift register (serial data input, shift enable, clear) plus a downstream output latch.
- Accepts a parallel word from an upstream producer over a valid/ready handshake and serialises it MSB-first into the shift register, one bit per enabled cycle.
- After the last bit it strobes the latch and, optionally, waits a programmable gap before accepting the next word.
- Also sequences a clear of the shift register on request.

Parameters:
- WIDTH, 4, word width in bits and number of shift cycles per word; legal range WIDTH >= 2.
- GAP_CYCLES, 1, idle cycles inserted after each latch strobe before in_ready reasserts; legal range >= 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  word to serialise; sampled on handshake.
- clear_req  input  1  request to clear the shift register; level, held by requester until serviced.
- sr_serial  output  1  serial bit to the shift register input.
- sr_shift_en  output  1  shift register advances on the next clk edge when high.
- sr_clear  output  1  one-cycle synchronous clear for the shift register.
- sr_latch  output  1  one-cycle strobe; the downstream latch captures the shift register contents.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, coincident with sr_latch.

Behaviour:
- Interface: reset is asynchronous and active-high. clk is the clock.
- Reset state:
  - State is IDLE; hold register, bit counter and gap counter are 0.
  - sr_serial, sr_shift_en, sr_clear, sr_latch, busy and done are all 0.
  - in_ready = !clear_req.
- Outputs are decoded from registered state only, with one exception: in_ready = (state==IDLE) && !clear_req.
- States: IDLE, CLEAR, SHIFT, LATCH, GAP.
- IDLE:
  - clear_req=1 -> CLEAR. clear_req has priority over in_valid; in_ready is low, so no handshake occurs that cycle.
  - Otherwise, in_valid && in_ready -> capture in_data into hold, bit_cnt=0, go to SHIFT.
- CLEAR:
  - sr_clear=1 for exactly one cycle, then -> IDLE.
  - If clear_req is still high on return to IDLE, a second clear is issued. The requester drops clear_req after observing sr_clear.
- SHIFT:
  - sr_shift_en=1 and sr_serial=hold[WIDTH-1] every cycle.
  - Each cycle hold shifts left by 1 (zero-fill) and bit_cnt increments.
  - On bit_cnt==WIDTH-1 -> LATCH. The state lasts exactly WIDTH cycles.
  - bit_cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- LATCH:
  - sr_latch=1 and done=1 for one cycle; sr_shift_en=0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - gap_cnt counts 0..GAP_CYCLES-1, then -> IDLE.
  - gap_cnt is $clog2(GAP_CYCLES+1) bits wide.
- Latency:
  - Handshake at edge k: shift cycles are k+1..k+WIDTH, sr_latch in cycle k+WIDTH+1, in_ready high again in cycle k+WIDTH+2+GAP_CYCLES.
  - Maximum throughput is one word per WIDTH+2+GAP_CYCLES cycles.
- Outside IDLE, in_valid, in_data and clear_req are ignored. in_data need not be held after the handshake.
- Reset mid-operation: immediate return to IDLE. No sr_latch or done is issued for the aborted word, and the shift register is left with partial contents.
- sr_shift_en, sr_clear and sr_latch are mutually exclusive in every cycle.

Optional Feature:
- Macro SHIFT_REG_CTRL_LSB_FIRST_EN.
- Defined:
  - sr_serial = hold[0] and hold shifts right each SHIFT cycle, so the word is sent LSB-first.
  - The external register then holds the bit-reversed word. All timing is unchanged.
- Undefined: MSB-first as specified above.

Test Plan:
- Reset value: reset=1 with clear_req=0 -> in_ready=1; all other outputs 0; state IDLE.
- Single word (WIDTH=4, GAP_CYCLES=1), in_data=4'b1011 accepted at edge k:
  - sr_serial sequence 1,0,1,1 with sr_shift_en high in cycles k+1..k+4.
  - sr_latch=done=1 in cycle k+5; model shift register equals 4'b1011 at the latch.
  - in_ready returns high in cycle k+7.
- Back-to-back traffic: in_valid held high with 4'hA then 4'h5 -> latch pulses exactly 7 cycles apart; captured words are A then 5.
- Clear priority: clear_req=1 and in_valid=1 together in IDLE:
  - in_ready=0; sr_clear pulses 1 cycle.
  - After clear_req drops, the word is accepted on the next cycle; model register reads 0 before the shift.
- Reset mid-shift: assert reset after 2 SHIFT cycles -> sr_shift_en drops immediately; sr_latch and done never pulse for that word; the next word is serialised correctly.
- Gap and feature: GAP_CYCLES=0 gives latch spacing of 6 cycles. With SHIFT_REG_CTRL_LSB_FIRST_EN, in_data=4'b1011 gives sr_serial sequence 1,1,0,1.
